adder_tree_feeder: RTL and testbench
====================================

ADDER_TREE_FEEDER -- requirements
Module: adder_tree_feeder

Interface
REQ-001 Parameter ADDER_WIDTH, default 24, operand width W in bits.
REQ-002 Parameter LATENCY, default 2, clock edges from group issue to valid tree sum; legal range 1..15.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream operand valid.
REQ-006 in_ready  output  1  block accepts operand this cycle.
REQ-007 in_data  input  W  operand.
REQ-008 op_bus  output  8*W  eight operands to the adder tree; operand k at bits [k*W+W-1:k*W], k = arrival order 0..7.
REQ-009 op_valid  output  1  one-cycle pulse: op_bus holds a complete new group.
REQ-010 tree_sum  input  W+1  registered sum returned by the adder tree.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  downstream accepts result.
REQ-013 res_sum  output  W+3  full-precision local sum of the group.
REQ-014 res_match  output  1  tree_sum equals res_sum[W:0].
REQ-015 err_count  output  8  count of mismatched groups, saturating.

Function
REQ-016 The FSM SHALL have states FILL, ISSUE, WAIT, RESULT; reset state is FILL.
REQ-017 In FILL, in_ready SHALL be 1; in all other states, 0.
REQ-018 An operand is accepted only on an edge where in_valid and in_ready are both 1; the operand is written to slot idx (3-bit counter), idx increments, and the W+3-bit accumulator adds the zero-extended operand.
REQ-019 The first accept of a group SHALL load the accumulator with the operand rather than add it.
REQ-020 The 8th accept (idx = 7) SHALL move FILL->ISSUE and wrap idx to 0.
REQ-021 ISSUE lasts exactly one cycle with op_valid = 1, then moves to WAIT; this cycle is T.
REQ-022 WAIT SHALL count edges and sample tree_sum on the edge ending cycle T+LATENCY, i.e. the sample is taken LATENCY edges after the edge that ends T, then move to RESULT.
REQ-023 On that sample edge, res_sum <= accumulator and res_match <= (tree_sum == accumulator[W:0]). The tree output is W+1 bits, so the top two accumulator bits are excluded from the compare.
REQ-024 If the compare fails and err_count < 255, err_count SHALL increment on the same edge; at 255 it holds.
REQ-025 In RESULT, res_valid SHALL be 1 and res_sum and res_match held stable until res_valid and res_ready are both high on an edge, then the FSM moves to FILL.
REQ-026 The handshake edge SHALL NOT accept an operand, because in_ready is 0 in RESULT.
REQ-027 op_bus SHALL change only by slot writes in FILL. Slots not yet rewritten keep the previous group's values.
REQ-028 res_sum and res_match SHALL remain at their last values after the handshake until the next sample.
REQ-029 in_valid without an accept SHALL have no effect; gaps between operands are unlimited.
REQ-030 res_ready asserted outside RESULT SHALL be ignored.

Reset
REQ-031 While rst_n = 0, regardless of clk, the outputs SHALL take these values: state FILL, idx 0, accumulator 0, op_bus 0, op_valid 0, in_ready 1 after release, res_valid 0, res_sum 0, res_match 0, err_count 0.
REQ-032 Reset mid-group or mid-WAIT SHALL discard the partial group. The first group after release starts at slot 0.

Verification
REQ-033 W=24, LATENCY=2, operands 1..8 back-to-back, tree_sum = 36 at T+2 -> op_valid pulse one cycle after the 8th accept; res_sum = 36, res_match = 1, err_count = 0.
REQ-034 Eight operands 0xFFFFFF, tree_sum = 0x1FFFFF8 -> res_sum = 0x7FFFFF8, res_match = 1 (truncated compare).
REQ-035 Operands all 5, tree_sum forced to 41 -> res_match = 0, err_count = 1. Then 260 forced-mismatch groups -> err_count = 255.
REQ-036 Random in_valid gaps with res_ready held 0 for 10 cycles -> in_ready = 0 and res_valid/res_sum stable throughout, then exactly one handshake returns the FSM to FILL.
REQ-037 rst_n pulsed low after 5 accepts, then operands 10..80 step 10 -> res_sum = 360; no prior operand is included.
REQ-038 LATENCY=4 with the tree model delayed accordingly -> sample on the edge ending T+4; res_match = 1.

Source files
------------

// File: rtl/adder_tree_feeder.sv
// Collects eight operands, presents them to an external adder tree, and checks
// the tree's registered sum against a locally accumulated full-precision sum.
module adder_tree_feeder #(
    parameter int ADDER_WIDTH = 24,
    parameter int LATENCY     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDER_WIDTH-1:0]     in_data,
    output logic [8*ADDER_WIDTH-1:0]   op_bus,
    output logic                       op_valid,
    input  logic [ADDER_WIDTH:0]       tree_sum,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ADDER_WIDTH+2:0]     res_sum,
    output logic                       res_match,
    output logic [7:0]                 err_count
);

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;
    localparam logic [3:0] LAT    = 4'(LATENCY);

    logic [1:0]             state;
    logic [2:0]             idx;
    logic [ADDER_WIDTH+2:0] acc;
    logic [ADDER_WIDTH+2:0] operand_ext;
    logic [3:0]             wait_cnt;
    logic                   accept;
    logic                   sample;

    assign in_ready    = (state == FILL);
    assign op_valid    = (state == ISSUE);
    assign res_valid   = (state == RESULT);
    assign accept      = in_valid && in_ready;
    assign operand_ext = {3'b000, in_data};
    // Tree sum is taken on the edge that ends cycle T+LATENCY.
    assign sample      = (state == WAIT) && (wait_cnt == LAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            idx      <= 3'd0;
            acc      <= '0;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        idx <= idx + 3'd1;
                        acc <= (idx == 3'd0) ? operand_ext : acc + operand_ext;
                        if (idx == 3'd7) begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= 4'd1;
                end
                WAIT: begin
                    if (sample) begin
                        state <= RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    if (res_ready) begin
                        state <= FILL;
                    end
                end
            endcase
        end
    end

    // Slots are only rewritten by accepts, so stale slots show the prior group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_bus <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (accept && (idx == 3'(k))) begin
                    op_bus[k*ADDER_WIDTH +: ADDER_WIDTH] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum   <= '0;
            res_match <= 1'b0;
            err_count <= 8'd0;
        end else if (sample) begin
            res_sum   <= acc;
            res_match <= (tree_sum == acc[ADDER_WIDTH:0]);
            if ((tree_sum != acc[ADDER_WIDTH:0]) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Randomized scoreboard bench for adder_tree_feeder, with a delayed adder-tree
// model and a second instance at LATENCY=4.
module tb_adder_tree_feeder;

    localparam int W   = 24;
    localparam int LAT = 2;

    typedef struct {
        logic [8*W-1:0] ops;
        logic [W:0]     tree;
    } op_t;

    typedef struct {
        logic [W+2:0] sum;
        logic         match;
        logic [7:0]   err;
    } res_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic [8*W-1:0] op_bus;
    logic           op_valid;
    logic [W:0]     tree_sum;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [W+2:0]   res_sum;
    logic           res_match;
    logic [7:0]     err_count;

    logic           in_ready4;
    logic [8*W-1:0] op_bus4;
    logic           op_valid4;
    logic [W:0]     tree_sum4;
    logic           res_valid4;
    logic [W+2:0]   res_sum4;
    logic           res_match4;
    logic [7:0]     err_count4;

    op_t        opq[$];
    res_t       resq[$];
    int         total = 0;
    int         bad = 0;
    int         exp_err = 0;
    int         rr_mode = 0;
    logic [W:0] tree_next = '0;
    logic [W:0] pipe [LAT];
    logic [W:0] pipe4 [4];
    int         lat4 = -1;
    int         n4 = 0;

    adder_tree_feeder #(.ADDER_WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .op_bus(op_bus), .op_valid(op_valid),
        .tree_sum(tree_sum), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_match(res_match), .err_count(err_count)
    );

    adder_tree_feeder #(.ADDER_WIDTH(W), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(1'b1), .in_ready(in_ready4),
        .in_data(24'd3), .op_bus(op_bus4), .op_valid(op_valid4),
        .tree_sum(tree_sum4), .res_valid(res_valid4), .res_ready(1'b1),
        .res_sum(res_sum4), .res_match(res_match4), .err_count(err_count4)
    );

    always #5 clk = ~clk;

    // Adder-tree model: a group's sum emerges LATENCY edges after issue, junk otherwise.
    always @(posedge clk) begin
        pipe[0] <= op_valid ? tree_next : (W+1)'($urandom);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        pipe4[0] <= op_valid4 ? (W+1)'(24) : (W+1)'($urandom);
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign tree_sum  = pipe[LAT-1];
    assign tree_sum4 = pipe4[3];

    // Downstream ready: random, held low, or held high depending on the test phase.
    always @(posedge clk) begin
        #2;
        res_ready = (rr_mode == 1) ? 1'b0 : (rr_mode == 2) ? 1'b1 : 1'($urandom_range(1));
    end

    task automatic checkOutput(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues a group or hands off a result.
    always @(negedge clk) begin
        op_t  eo;
        res_t er;
        if (rst_n) begin
            if (op_valid) begin
                if (opq.size() == 0) begin
                    checkOutput("op_unexpected", 1, 0);
                end else begin
                    eo = opq.pop_front();
                    checkOutput("op_bus", op_bus, eo.ops);
                    tree_next = eo.tree;
                end
            end
            if (res_valid && res_ready) begin
                if (resq.size() == 0) begin
                    checkOutput("res_unexpected", 1, 0);
                end else begin
                    er = resq.pop_front();
                    checkOutput("res_sum", res_sum, er.sum);
                    checkOutput("res_match", res_match, er.match);
                    checkOutput("err_count", err_count, er.err);
                end
            end
        end
    end

    // LATENCY=4 instance: result must appear five cycles after the issue cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            lat4 = -1;
        end else begin
            if (op_valid4) lat4 = 0;
            else if (lat4 >= 0) lat4++;
            if (res_valid4 && lat4 > 0 && n4 < 4) begin
                checkOutput("lat4_cycles", lat4, 5);
                checkOutput("lat4_match", res_match4, 1);
                checkOutput("lat4_sum", res_sum4, 24);
                n4++;
                lat4 = -1;
            end
        end
    end

    task automatic abortRun(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timeout waiting for DUT", name);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] aborted");
    endtask

    task automatic sendOp(input logic [W-1:0] d, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) abortRun("accept_wait");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [W-1:0] ops [8], input bit force_bad, input int maxgap, input bit stall);
        logic [W+2:0]   s;
        logic [8*W-1:0] vec;
        op_t            eo;
        res_t           er;
        s   = '0;
        vec = '0;
        for (int k = 0; k < 8; k++) begin
            sendOp(ops[k], $urandom_range(maxgap));
            s = s + {3'b000, ops[k]};
            vec[k*W +: W] = ops[k];
        end
        if (stall) rr_mode = 1;
        eo.ops  = vec;
        eo.tree = force_bad ? s[W:0] + 1'b1 : s[W:0];
        opq.push_back(eo);
        if (force_bad && exp_err < 255) exp_err++;
        er.sum   = s;
        er.match = !force_bad;
        er.err   = 8'(exp_err);
        resq.push_back(er);
        @(negedge clk);
        checkOutput("op_valid_pulse", op_valid, 1);
        repeat (LAT) begin
            @(negedge clk);
            checkOutput("res_valid_early", res_valid, 0);
        end
        @(negedge clk);
        checkOutput("res_valid_latency", res_valid, 1);
        if (stall) begin
            repeat (10) begin
                @(negedge clk);
                checkOutput("stall_in_ready", in_ready, 0);
                checkOutput("stall_res_valid", res_valid, 1);
                checkOutput("stall_res_sum", res_sum, s);
            end
            rr_mode = 2;
            @(posedge clk);
            @(posedge clk);
            #1;
            rr_mode = 0;
            @(negedge clk);
            checkOutput("release_in_ready", in_ready, 1);
            checkOutput("release_res_valid", res_valid, 0);
            checkOutput("res_sum_hold", res_sum, s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_op_bus", op_bus, 0);
        checkOutput("rst_op_valid", op_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_sum", res_sum, 0);
        checkOutput("rst_res_match", res_match, 0);
        checkOutput("rst_err_count", err_count, 0);
    endtask

    initial begin
        logic [W-1:0] g [8];
        int n;
        rst_n = 1'b0;
        #23;
        checkResetValues();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) g[k] = W'(k + 1);
        applyStimulus(g, 1'b0, 0, 1'b0);
        for (int k = 0; k < 8; k++) g[k] = 24'hFFFFFF;
        applyStimulus(g, 1'b0, 2, 1'b0);
        for (int k = 0; k < 8; k++) g[k] = 24'd5;
        applyStimulus(g, 1'b1, 1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 8; k++) g[k] = W'($urandom);
            applyStimulus(g, ($urandom_range(3) == 0), 3, 1'b0);
        end

        for (int k = 0; k < 8; k++) g[k] = W'($urandom_range(1000));
        applyStimulus(g, 1'b0, 2, 1'b1);

        // Abandon a partial group with reset; the next group must start fresh at slot 0.
        for (int k = 0; k < 5; k++) sendOp(W'(100 + k), 1);
        rst_n = 1'b0;
        #3;
        checkResetValues();
        opq.delete();
        resq.delete();
        exp_err = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) g[k] = W'(10 * (k + 1));
        applyStimulus(g, 1'b0, 1, 1'b0);

        for (int r = 0; r < 260; r++) begin
            for (int k = 0; k < 8; k++) g[k] = W'($urandom_range(255));
            applyStimulus(g, 1'b1, 0, 1'b0);
        end

        n = 0;
        while (resq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drained", resq.size(), 0);
        checkOutput("final_err_sat", err_count, 255);
        checkOutput("lat4_results_seen", (n4 >= 3), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
